epass_checker: RTL
==================

# epass_checker

Toll-lane Epass responder serving the lane controller's fee-calculation request. While the controller holds `cal` high, the block waits for a card and looks up the card's balance in an internal account table. It deducts the fee on success and returns the verdict on `valid_Epass` using the encoding the controller decodes. It also owns the account table top-up/registration port and lane accept/reject statistics.

## Interface
Parameters:
- NUM_CARDS, 16: number of account entries; valid ids are 0..NUM_CARDS-1.
- ID_W, 5: card id width; ids >= NUM_CARDS are representable and must be rejected.
- BAL_W, 16: balance, fee and top-up width (unsigned).
- TIMEOUT, 1000: cycles to wait for a card before rejecting; must be >= 2.
- CNT_W, 16: statistics counter width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- cal  in  1  request level from the controller, held while it waits for a verdict.
- card_present  in  1  card reader has a valid id on card_id.
- card_id  in  ID_W  card identifier.
- fee  in  BAL_W  toll amount for the current vehicle.
- wr_en  in  1  account write strobe.
- wr_register  in  1  with wr_en: mark wr_id registered and clear its balance to 0.
- wr_id  in  ID_W  account written.
- wr_amount  in  BAL_W  top-up amount, used when wr_en=1 and wr_register=0.
- valid_Epass  out  2  00 idle, 11 in progress, 10 accept, 01 reject.
- reason  out  2  00 ok, 01 unregistered/out-of-range, 10 insufficient balance, 11 timeout.
- balance_out  out  BAL_W  post-transaction balance of the served card (0 on reject without lookup).
- accept_cnt  out  CNT_W  accepted transactions, wrapping.
- reject_cnt  out  CNT_W  rejected transactions, wrapping.

## Operation
- Reset: state IDLE, valid_Epass=00, reason=00, balance_out=0, both counters 0, all balances 0, all registered bits 0.
- IDLE:
  - cal=1 and card_present=1: capture card_id and fee, go to LOOKUP.
  - cal=1 and card_present=0: clear the timer, go to WAIT_CARD.
- WAIT_CARD:
  - card_present=1: capture id and fee, go to LOOKUP.
  - Timer reaches TIMEOUT-1 with no card: go to RESPOND with reject, reason=11.
- LOOKUP: register the entry's balance and registered bit into bal_q and reg_q; the id range check is done here. Go to DECIDE.
- DECIDE:
  - Out of range or reg_q=0: reject, reason=01, no write.
  - bal_q < fee_q: reject, reason=10, no write.
  - Otherwise: accept, reason=00, entry balance -= fee_q.
  - balance_out is the post-transaction balance (bal_q on insufficient-balance reject, 0 on out-of-range or unregistered reject).
  - Increment the matching counter. Go to RESPOND.
- RESPOND: hold valid_Epass, reason and balance_out until cal=0, then return to IDLE with valid_Epass=00.
- valid_Epass=11 in WAIT_CARD, LOOKUP and DECIDE.
- Abort: cal=0 in WAIT_CARD, LOOKUP or DECIDE returns to IDLE next cycle with valid_Epass=00. No deduction and no counter change occur, even if the abort lands on the DECIDE cycle; an abort in DECIDE cancels that cycle's deduction.
- Account port:
  - Writes are accepted every cycle in every state.
  - Top-up saturates at 2^BAL_W-1.
  - Top-up of an unregistered entry is ignored.
  - wr_id >= NUM_CARDS is ignored.
  - wr_register on an already registered entry resets its balance to 0.
- Same-entry collision in DECIDE:
  - Top-up plus deduct: new = sat(bal_q - fee_q + wr_amount). The verdict uses the pre-top-up bal_q.
  - wr_register plus deduct: the register wins, balance becomes 0, and the verdict still stands.
- fee=0 on a registered card: accept, balance unchanged.

## Timing
- All outputs are registered.
- Card present at request: cal and card_present sampled in IDLE at edge N.
  - valid_Epass=11 from N+1 (LOOKUP); DECIDE occurs at N+2.
  - Verdict visible from N+3.
  - Table updated at edge N+3.
- Card arriving later: card seen in WAIT_CARD at edge M gives the same 3-cycle latency from M.
- Timeout: WAIT_CARD entered at edge E; reject visible at E+TIMEOUT.
- Release: cal=0 sampled in RESPOND at edge R gives valid_Epass=00 at R+1. A new request is accepted from R+1 onward, so the minimum gap between requests is one cycle.
- Reset asserted mid-transaction: at the next edge everything returns to reset values, including the table.

## Test plan
- Register id 3, top up 500, cal with card 3, fee 120 -> 11 for 2 cycles, then 10, reason 00, balance_out 380, accept_cnt 1.
- Card 3 with balance 100, fee 120 -> 01, reason 10, balance_out 100, balance unchanged.
- Card 20 (out of range) and unregistered card 5 -> 01, reason 01, reject_cnt +1 each.
- cal held with no card, TIMEOUT=8 -> 11 for 8 cycles, then 01 with reason 11; drop cal -> 00 next cycle.
- Top-up 50 to id 3 in the DECIDE cycle, balance 200, fee 120 -> accept, final balance 130. Top-up to balance 65500 with BAL_W=16 -> saturates at 65535.
- Drop cal during LOOKUP, and separately during DECIDE -> 00, no deduction, counters unchanged. Reset during RESPOND -> all outputs and the table cleared.

Source files
------------

// File: rtl/epass_checker.sv
// epass_checker
//   Toll-lane Epass responder. While the lane controller holds cal, waits for
//   a card, looks up its balance in an internal account table, deducts the fee
//   on success and reports the verdict on valid_Epass. Also owns the account
//   top-up/registration port and the accept/reject statistics.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   cal                   request level from the lane controller
//   card_present, card_id card reader id and its qualifier
//   fee                   toll for the current vehicle
//   wr_en, wr_register,   account port: register (clear balance) or top up
//   wr_id, wr_amount
//   valid_Epass           00 idle, 11 in progress, 10 accept, 01 reject
//   reason                00 ok, 01 unregistered/out-of-range, 10 low balance, 11 timeout
//   balance_out           post-transaction balance of the served card
//   accept_cnt/reject_cnt wrapping transaction statistics
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no request; valid_Epass = 00
// S_WAIT    | cal high, waiting for a card, timeout timer running
// S_LOOKUP  | card captured, reading the account entry
// S_DECIDE  | compare balance with fee, deduct and count on accept/reject
// S_RESPOND | verdict held until cal drops

module epass_checker #(
  parameter int NUM_CARDS = 16,
  parameter int ID_W      = 5,
  parameter int BAL_W     = 16,
  parameter int TIMEOUT   = 1000,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cal,
  input  logic             card_present,
  input  logic [ID_W-1:0]  card_id,
  input  logic [BAL_W-1:0] fee,
  input  logic             wr_en,
  input  logic             wr_register,
  input  logic [ID_W-1:0]  wr_id,
  input  logic [BAL_W-1:0] wr_amount,
  output logic [1:0]       valid_Epass,
  output logic [1:0]       reason,
  output logic [BAL_W-1:0] balance_out,
  output logic [CNT_W-1:0] accept_cnt,
  output logic [CNT_W-1:0] reject_cnt
);

  localparam int IDX_W = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [ID_W:0] NUM_ID = (ID_W+1)'(NUM_CARDS);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_LOOKUP, S_DECIDE, S_RESPOND
  } state_t;

  state_t state, state_nxt;

  logic [TMR_W-1:0] timer;
  logic [ID_W-1:0]  id_q;
  logic [BAL_W-1:0] fee_q;
  logic [BAL_W-1:0] bal_q;
  logic             reg_q;
  logic             in_range_q;

  logic [BAL_W-1:0]     bal_tab [NUM_CARDS];
  logic [NUM_CARDS-1:0] reg_tab;

  logic [1:0]       valid_nxt;
  logic [1:0]       reason_nxt;
  logic [BAL_W-1:0] bal_out_nxt;
  logic             acc_inc;
  logic             rej_inc;
  logic             deduct;

  logic [NUM_CARDS-1:0] wr_hit;
  logic [NUM_CARDS-1:0] ded_hit;
  logic [BAL_W-1:0]     bal_after_fee;

  function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0] a,
                                               input logic [BAL_W-1:0] b);
    logic [BAL_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[BAL_W] ? {BAL_W{1'b1}} : sum[BAL_W-1:0];
  endfunction

  assign bal_after_fee = bal_q - fee_q;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state logic; dropping cal aborts from any in-flight state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (cal) state_nxt = card_present ? S_LOOKUP : S_WAIT;
      S_WAIT: begin
        if (!cal)              state_nxt = S_IDLE;
        else if (card_present) state_nxt = S_LOOKUP;
        else if (timer == '0)  state_nxt = S_RESPOND;
      end
      S_LOOKUP:  state_nxt = cal ? S_DECIDE : S_IDLE;
      S_DECIDE:  state_nxt = cal ? S_RESPOND : S_IDLE;
      S_RESPOND: if (!cal) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // output logic: next values of the registered outputs plus side effects
  always_comb begin
    valid_nxt   = valid_Epass;
    reason_nxt  = reason;
    bal_out_nxt = balance_out;
    acc_inc     = 1'b0;
    rej_inc     = 1'b0;
    deduct      = 1'b0;
    case (state_nxt)
      S_IDLE:                     valid_nxt = 2'b00;
      S_WAIT, S_LOOKUP, S_DECIDE: valid_nxt = 2'b11;
      default: ;
    endcase
    if (state == S_WAIT && state_nxt == S_RESPOND) begin
      valid_nxt   = 2'b01;
      reason_nxt  = 2'b11;
      bal_out_nxt = '0;
      rej_inc     = 1'b1;
    end
    if (state == S_DECIDE && state_nxt == S_RESPOND) begin
      if (!in_range_q || !reg_q) begin
        valid_nxt   = 2'b01;
        reason_nxt  = 2'b01;
        bal_out_nxt = '0;
        rej_inc     = 1'b1;
      end else if (bal_q < fee_q) begin
        valid_nxt   = 2'b01;
        reason_nxt  = 2'b10;
        bal_out_nxt = bal_q;
        rej_inc     = 1'b1;
      end else begin
        valid_nxt   = 2'b10;
        reason_nxt  = 2'b00;
        bal_out_nxt = bal_after_fee;
        acc_inc     = 1'b1;
        deduct      = 1'b1;
      end
    end
  end

  // outputs, counters, timer and transaction capture
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_Epass <= 2'b00;
      reason      <= 2'b00;
      balance_out <= '0;
      accept_cnt  <= '0;
      reject_cnt  <= '0;
      timer       <= '0;
      id_q        <= '0;
      fee_q       <= '0;
      bal_q       <= '0;
      reg_q       <= 1'b0;
      in_range_q  <= 1'b0;
    end else begin
      valid_Epass <= valid_nxt;
      reason      <= reason_nxt;
      balance_out <= bal_out_nxt;
      if (acc_inc) accept_cnt <= accept_cnt + CNT_W'(1);
      if (rej_inc) reject_cnt <= reject_cnt + CNT_W'(1);

      // down-counter: loaded on WAIT entry, terminal count 0 means timeout
      if (state != S_WAIT && state_nxt == S_WAIT) timer <= TMR_LOAD;
      else if (state == S_WAIT && timer != '0)    timer <= timer - TMR_W'(1);

      if (state_nxt == S_LOOKUP) begin
        id_q  <= card_id;
        fee_q <= fee;
      end

      if (state == S_LOOKUP) begin
        in_range_q <= ({1'b0, id_q} < NUM_ID);
        if ({1'b0, id_q} < NUM_ID) begin
          bal_q <= bal_tab[id_q[IDX_W-1:0]];
          reg_q <= reg_tab[id_q[IDX_W-1:0]];
        end else begin
          bal_q <= '0;
          reg_q <= 1'b0;
        end
      end
    end
  end

  // per-entry write decode; out-of-range ids match no entry
  always_comb begin
    wr_hit  = '0;
    ded_hit = '0;
    for (int i = 0; i < NUM_CARDS; i++) begin
      wr_hit[i]  = wr_en && (wr_id == ID_W'(i));
      ded_hit[i] = deduct && (id_q == ID_W'(i));
    end
  end

  // account table: register beats deduct; top-up stacks on top of the deduct
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_tab <= '0;
      for (int i = 0; i < NUM_CARDS; i++) bal_tab[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CARDS; i++) begin
        if (wr_hit[i] && wr_register) begin
          reg_tab[i] <= 1'b1;
          bal_tab[i] <= '0;
        end else if (wr_hit[i] && reg_tab[i]) begin
          bal_tab[i] <= sat_add(ded_hit[i] ? bal_after_fee : bal_tab[i], wr_amount);
        end else if (ded_hit[i]) begin
          bal_tab[i] <= bal_after_fee;
        end
      end
    end
  end

endmodule
